rfb_to_hub75_seq: RTL and testbench

- Parametrised successor to the two-channel rotational-frame-buffer to HUB75 column feeder.
- Captures one rotational slice per frame: NUM_CHANNELS radii, each with a NUM_ROWS-bit on/off column.
- Expands each on-pixel to a programmable RGB_RES-bit colour, then serialises one HUB75 beat per channel using a valid/ready handshake.
- Optionally skips all-blank channels. Sits between the rotational frame buffer read port and the hub75 driver.

---
 rtl/rfb_to_hub75_seq_if.sv | 53 +++++
 rtl/rfb_to_hub75_seq.sv | 177 +++++++++++++++++
 tb/tb_rfb_to_hub75_seq.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rfb_to_hub75_seq_if.sv
// -----------------------------------------------------------------------------
// rfb_to_hub75_seq_if
// Bundles the slice-capture handshake (from the rotational frame buffer) and the
// beat handshake (towards the hub75 driver) of rfb_to_hub75_seq.
//
// Signals:
//   in_valid / in_ready      slice handshake
//   radii_input              NUM_CHANNELS*RW column numbers
//   rfb_cols_input           NUM_CHANNELS*NUM_ROWS on/off pixels
//   fg_color_in              colour applied to on-pixels
//   skip_blank_in            drop channels whose column is all zero
//   hub75_ready / data_valid beat handshake
//   col_num, chan_out        column number and channel index of the beat
//   columns                  beat payload, one RGB_RES word per row per channel
//   frame_done               one-cycle end-of-slice pulse
//
// Modports: master = the side driving slices and accepting beats,
//           slave  = the feeder block itself.
// -----------------------------------------------------------------------------
interface rfb_to_hub75_seq_if #(
    parameter int NUM_CHANNELS = 2,
    parameter int SCAN_RATE    = 32,
    parameter int NUM_ROWS     = 64,
    parameter int RGB_RES      = 9
);
    localparam int RW = $clog2(SCAN_RATE);
    localparam int CW = ($clog2(NUM_CHANNELS) > 0) ? $clog2(NUM_CHANNELS) : 1;

    logic                                      in_valid;
    logic                                      in_ready;
    logic [NUM_CHANNELS*RW-1:0]                radii_input;
    logic [NUM_CHANNELS*NUM_ROWS-1:0]          rfb_cols_input;
    logic [RGB_RES-1:0]                        fg_color_in;
    logic                                      skip_blank_in;
    logic                                      hub75_ready;
    logic                                      data_valid;
    logic [RW-1:0]                             col_num;
    logic [CW-1:0]                             chan_out;
    logic [NUM_CHANNELS*NUM_ROWS*RGB_RES-1:0]  columns;
    logic                                      frame_done;

    modport master (
        output in_valid, radii_input, rfb_cols_input, fg_color_in, skip_blank_in,
        output hub75_ready,
        input  in_ready, data_valid, col_num, chan_out, columns, frame_done
    );

    modport slave (
        input  in_valid, radii_input, rfb_cols_input, fg_color_in, skip_blank_in,
        input  hub75_ready,
        output in_ready, data_valid, col_num, chan_out, columns, frame_done
    );
endinterface

// File: rtl/rfb_to_hub75_seq.sv
// -----------------------------------------------------------------------------
// rfb_to_hub75_seq
// Captures one rotational slice (NUM_CHANNELS radii, each with a NUM_ROWS-bit
// on/off column), expands on-pixels to the captured foreground colour and
// emits one HUB75 beat per kept channel over a valid/ready handshake.
// Channels whose column is blank can be skipped; frame_done pulses once the
// slice has been fully sent (or fully skipped).
//
// Ports:
//   clk_in    system clock, rising edge
//   rst_n_in  synchronous active-low reset
//   bus       rfb_to_hub75_seq_if.slave (slice input + beat output)
// -----------------------------------------------------------------------------
module rfb_to_hub75_seq #(
    parameter int NUM_CHANNELS = 2,
    parameter int SCAN_RATE    = 32,
    parameter int NUM_ROWS     = 64,
    parameter int RGB_RES      = 9
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    rfb_to_hub75_seq_if.slave bus
);
    localparam int RW     = $clog2(SCAN_RATE);
    localparam int CW     = ($clog2(NUM_CHANNELS) > 0) ? $clog2(NUM_CHANNELS) : 1;
    localparam int PIX_W  = NUM_CHANNELS * NUM_ROWS;
    localparam int COLS_W = PIX_W * RGB_RES;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                          state;
    logic [NUM_CHANNELS*RW-1:0]      radii_q;
    logic [PIX_W-1:0]                cols_q;
    logic [RGB_RES-1:0]              color_q;
    logic [NUM_CHANNELS-1:0]         keep_q;
    logic [CW-1:0]                   ptr;

    logic                            in_ready_q;
    logic                            data_valid_q;
    logic [RW-1:0]                   col_num_q;
    logic [CW-1:0]                   chan_q;
    logic [COLS_W-1:0]               columns_q;
    logic                            frame_done_q;

    logic [NUM_CHANNELS-1:0]         keep_in;
    logic [CW:0]                     first_hit;
    logic [CW:0]                     next_hit;

    // Channel i is sent unless skipping is on and its column is all zero.
    function automatic logic [NUM_CHANNELS-1:0] keep_mask(
        input logic [PIX_W-1:0] cols,
        input logic             skip
    );
        logic [NUM_CHANNELS-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            m[i] = !skip || (|cols[i*NUM_ROWS +: NUM_ROWS]);
        end
        return m;
    endfunction

    // Lowest kept index >= start; MSB of the result flags a hit. Scanning from
    // the top down lets the last assignment win, i.e. the lowest index.
    function automatic logic [CW:0] find_kept(
        input logic [NUM_CHANNELS-1:0] keep,
        input int                      start
    );
        logic [CW:0] res;
        res = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (keep[i] && (i >= start)) begin
                res = {1'b1, CW'(i)};
            end
        end
        return res;
    endfunction

    function automatic logic [RW-1:0] radius_at(
        input logic [NUM_CHANNELS*RW-1:0] radii,
        input logic [CW-1:0]              idx
    );
        return radii[int'(idx)*RW +: RW];
    endfunction

    // Only the slot of channel idx carries pixels; every other slot stays zero.
    function automatic logic [COLS_W-1:0] expand(
        input logic [PIX_W-1:0]   cols,
        input logic [RGB_RES-1:0] color,
        input logic [CW-1:0]      idx
    );
        logic [COLS_W-1:0] res;
        int                base;
        res  = '0;
        base = int'(idx) * NUM_ROWS;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (cols[base + r]) begin
                res[(base + r)*RGB_RES +: RGB_RES] = color;
            end
        end
        return res;
    endfunction

    assign keep_in   = keep_mask(bus.rfb_cols_input, bus.skip_blank_in);
    assign first_hit = find_kept(keep_in, 0);
    assign next_hit  = find_kept(keep_q, int'(ptr) + 1);

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state        <= IDLE;
            in_ready_q   <= 1'b1;
            data_valid_q <= 1'b0;
            col_num_q    <= '0;
            chan_q       <= '0;
            columns_q    <= '0;
            frame_done_q <= 1'b0;
            radii_q      <= '0;
            cols_q       <= '0;
            color_q      <= '0;
            keep_q       <= '0;
            ptr          <= '0;
        end else begin
            frame_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        radii_q <= bus.radii_input;
                        cols_q  <= bus.rfb_cols_input;
                        color_q <= bus.fg_color_in;
                        keep_q  <= keep_in;
                        // The first beat is built straight from the inputs so it
                        // is presented the cycle after capture.
                        if (first_hit[CW]) begin
                            state        <= SEND;
                            ptr          <= first_hit[CW-1:0];
                            in_ready_q   <= 1'b0;
                            data_valid_q <= 1'b1;
                            chan_q       <= first_hit[CW-1:0];
                            col_num_q    <= radius_at(bus.radii_input, first_hit[CW-1:0]);
                            columns_q    <= expand(bus.rfb_cols_input, bus.fg_color_in,
                                                   first_hit[CW-1:0]);
                        end else begin
                            // Every channel skipped: nothing to send, slice ends now.
                            frame_done_q <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    // data_valid is always high here, so hub75_ready alone
                    // means the current beat is accepted.
                    if (bus.hub75_ready) begin
                        if (next_hit[CW]) begin
                            ptr       <= next_hit[CW-1:0];
                            chan_q    <= next_hit[CW-1:0];
                            col_num_q <= radius_at(radii_q, next_hit[CW-1:0]);
                            columns_q <= expand(cols_q, color_q, next_hit[CW-1:0]);
                        end else begin
                            state        <= IDLE;
                            in_ready_q   <= 1'b1;
                            data_valid_q <= 1'b0;
                            columns_q    <= '0;
                            frame_done_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.data_valid = data_valid_q;
    assign bus.col_num    = col_num_q;
    assign bus.chan_out   = chan_q;
    assign bus.columns    = columns_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_rfb_to_hub75_seq.sv
// -----------------------------------------------------------------------------
// tb_rfb_to_hub75_seq
// Bench for rfb_to_hub75_seq: a default (2-channel) instance for the basic
// slice, and a 4-channel instance for backpressure, blank skipping, colour,
// reset, back-to-back and randomized slices. Expected beats come from the list
// of kept channels computed from each slice.
// -----------------------------------------------------------------------------
module tb_rfb_to_hub75_seq;
    localparam int N4   = 4;
    localparam int ROWS = 64;
    localparam int RW   = 5;
    localparam int BW   = N4 * ROWS * 9;

    typedef logic [ROWS-1:0] cols_t [N4];
    typedef logic [RW-1:0]   radii_t [N4];

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    rfb_to_hub75_seq_if #(.NUM_CHANNELS(N4)) bus4 ();
    rfb_to_hub75_seq_if                      bus2 ();

    rfb_to_hub75_seq #(.NUM_CHANNELS(N4)) u_dut4 (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus4)
    );

    rfb_to_hub75_seq u_dut2 (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cols(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        int         first;
        logic [8:0] po;
        logic [8:0] pe;
        tests++;
        assert (obs === exp) else begin
            fails++;
            first = 0;
            for (int p = N4*ROWS - 1; p >= 0; p--) begin
                if (obs[p*9 +: 9] !== exp[p*9 +: 9]) first = p;
            end
            po = obs[first*9 +: 9];
            pe = exp[first*9 +: 9];
            $error("FAIL %s pixel %0d observed=%0h expected=%0h", tag, first, po, pe);
        end
    endtask

    // Beat payload for channel k: row r of slot k gets fg when the pixel is on.
    function automatic logic [BW-1:0] exp_columns(input cols_t c, input logic [8:0] fg, input int k);
        logic [BW-1:0] res;
        res = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (c[k][r]) res[(k*ROWS + r)*9 +: 9] = fg;
        end
        return res;
    endfunction

    task automatic drive4(input radii_t r, input cols_t c, input logic [8:0] fg, input logic skip);
        for (int i = 0; i < N4; i++) begin
            bus4.radii_input[i*RW +: RW]        = r[i];
            bus4.rfb_cols_input[i*ROWS +: ROWS] = c[i];
        end
        bus4.fg_color_in   = fg;
        bus4.skip_blank_in = skip;
    endtask

    // Garbage on the slice inputs once captured must not leak into beats.
    task automatic scramble4();
        bus4.radii_input    = 20'($urandom);
        bus4.rfb_cols_input = {8{$urandom}};
        bus4.fg_color_in    = 9'($urandom);
        bus4.skip_blank_in  = 1'($urandom);
    endtask

    task automatic chk_beat(input string tag, input radii_t r, input cols_t c,
                            input logic [8:0] fg, input int k);
        chk({tag, "_valid"}, 64'(bus4.data_valid), 64'd1);
        chk({tag, "_chan"}, 64'(bus4.chan_out), 64'(k));
        chk({tag, "_col"}, 64'(bus4.col_num), 64'(r[k]));
        chk_cols({tag, "_cols"}, bus4.columns, exp_columns(c, fg, k));
        chk({tag, "_done"}, 64'(bus4.frame_done), 64'd0);
        chk({tag, "_inrdy"}, 64'(bus4.in_ready), 64'd0);
    endtask

    task automatic chk_end(input string tag);
        chk({tag, "_end_valid"}, 64'(bus4.data_valid), 64'd0);
        chk_cols({tag, "_end_cols"}, bus4.columns, '0);
        chk({tag, "_end_done"}, 64'(bus4.frame_done), 64'd1);
        chk({tag, "_end_inrdy"}, 64'(bus4.in_ready), 64'd1);
    endtask

    // Capture one slice on the 4-channel instance and consume all its beats.
    // hold0 forces that many stall cycles on the first beat; stall_pct adds
    // random stalls afterwards.
    task automatic do_slice(input string tag, input radii_t r, input cols_t c,
                            input logic [8:0] fg, input logic skip,
                            input int hold0, input int stall_pct);
        int   kept[$];
        int   stalls;
        logic acc;
        for (int i = 0; i < N4; i++) begin
            if (!skip || c[i] != '0) kept.push_back(i);
        end
        drive4(r, c, fg, skip);
        bus4.in_valid = 1'b1;
        chk({tag, "_cap_inrdy"}, 64'(bus4.in_ready), 64'd1);
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        scramble4();
        if (kept.size() == 0) begin
            chk_end(tag);
        end else begin
            foreach (kept[j]) begin
                stalls = 0;
                acc    = 1'b0;
                while (!acc) begin
                    chk_beat(tag, r, c, fg, kept[j]);
                    bus4.in_valid = 1'($urandom);
                    scramble4();
                    acc = !(j == 0 && stalls < hold0) &&
                          (stalls >= 6 || $urandom_range(99) >= stall_pct);
                    bus4.hub75_ready = acc;
                    @(posedge clk); #1;
                    stalls++;
                end
            end
            bus4.in_valid = 1'b0;
            chk_end(tag);
        end
        bus4.hub75_ready = 1'($urandom);
        @(posedge clk); #1;
        chk({tag, "_post_done"}, 64'(bus4.frame_done), 64'd0);
        chk({tag, "_post_valid"}, 64'(bus4.data_valid), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        radii_t        r;
        radii_t        rb;
        cols_t         c;
        cols_t         cb;
        logic [8:0]    fg;
        logic [8:0]    fgb;
        logic [1151:0] e2;

        rst_n = 1'b0;
        bus4.in_valid = 1'b0; bus4.hub75_ready = 1'b0;
        bus4.radii_input = '0; bus4.rfb_cols_input = '0;
        bus4.fg_color_in = '0; bus4.skip_blank_in = 1'b0;
        bus2.in_valid = 1'b0; bus2.hub75_ready = 1'b1;
        bus2.radii_input = '0; bus2.rfb_cols_input = '0;
        bus2.fg_color_in = '0; bus2.skip_blank_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        chk("rst_inrdy", 64'(bus4.in_ready), 64'd1);
        chk("rst_valid", 64'(bus4.data_valid), 64'd0);
        chk("rst_col", 64'(bus4.col_num), 64'd0);
        chk("rst_chan", 64'(bus4.chan_out), 64'd0);
        chk_cols("rst_cols", bus4.columns, '0);
        chk("rst_done", 64'(bus4.frame_done), 64'd0);
        chk("rst2_inrdy", 64'(bus2.in_ready), 64'd1);
        chk("rst2_valid", 64'(bus2.data_valid), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic slice on the default 2-channel instance
        bus2.radii_input    = {5'd9, 5'd5};
        bus2.rfb_cols_input = {64'h8000_0000_0000_0000, 64'h1};
        bus2.fg_color_in    = 9'h1FF;
        bus2.in_valid       = 1'b1;
        @(posedge clk); #1;
        bus2.in_valid = 1'b0;
        e2 = '0; e2[8:0] = 9'h1FF;
        chk("b2_0_valid", 64'(bus2.data_valid), 64'd1);
        chk("b2_0_chan", 64'(bus2.chan_out), 64'd0);
        chk("b2_0_col", 64'(bus2.col_num), 64'd5);
        chk_cols("b2_0_cols", BW'(bus2.columns), BW'(e2));
        @(posedge clk); #1;
        e2 = '0; e2[127*9 +: 9] = 9'h1FF;
        chk("b2_1_chan", 64'(bus2.chan_out), 64'd1);
        chk("b2_1_col", 64'(bus2.col_num), 64'd9);
        chk_cols("b2_1_cols", BW'(bus2.columns), BW'(e2));
        chk("b2_1_done", 64'(bus2.frame_done), 64'd0);
        @(posedge clk); #1;
        chk("b2_end_done", 64'(bus2.frame_done), 64'd1);
        chk("b2_end_inrdy", 64'(bus2.in_ready), 64'd1);
        chk("b2_end_valid", 64'(bus2.data_valid), 64'd0);
        @(posedge clk); #1;
        chk("b2_post_done", 64'(bus2.frame_done), 64'd0);

        // Backpressure: beat 0 held for 4 stalled cycles
        r = '{5'd5, 5'd9, 5'd17, 5'd30};
        c = '{64'h1, 64'h8000_0000_0000_0000, 64'h0, 64'h0};
        do_slice("bp", r, c, 9'h1FF, 1'b1, 4, 0);

        // Skip blank channels: beats for 1 and 3 only
        r = '{5'd1, 5'd2, 5'd3, 5'd4};
        c = '{64'h0, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0, 64'h1};
        do_slice("skip", r, c, 9'h155, 1'b1, 0, 0);

        // All blank with skip: no beats, frame_done right after capture
        c = '{64'h0, 64'h0, 64'h0, 64'h0};
        do_slice("blank", r, c, 9'h0FF, 1'b1, 0, 0);

        // Colour expansion; fg changes after capture inside do_slice
        c = '{64'hF0, 64'h0, 64'h0, 64'h0};
        do_slice("color", r, c, 9'h0A5, 1'b0, 0, 0);

        // Reset mid-slice, then reset while in_valid is high
        r = '{5'd7, 5'd8, 5'd9, 5'd10};
        c = '{64'h3, 64'h5, 64'h9, 64'h11};
        drive4(r, c, 9'h1AB, 1'b0);
        bus4.hub75_ready = 1'b0;
        bus4.in_valid    = 1'b1;
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        chk("mrst_pre_valid", 64'(bus4.data_valid), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mrst_valid", 64'(bus4.data_valid), 64'd0);
        chk_cols("mrst_cols", bus4.columns, '0);
        chk("mrst_inrdy", 64'(bus4.in_ready), 64'd1);
        chk("mrst_done", 64'(bus4.frame_done), 64'd0);
        chk("mrst_chan", 64'(bus4.chan_out), 64'd0);
        chk("mrst_col", 64'(bus4.col_num), 64'd0);
        bus4.in_valid = 1'b1;
        @(posedge clk); #1;
        chk("mrst_cap_valid", 64'(bus4.data_valid), 64'd0);
        rst_n = 1'b1;
        bus4.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("mrst_rel_valid", 64'(bus4.data_valid), 64'd0);
        chk("mrst_rel_done", 64'(bus4.frame_done), 64'd0);

        // Back-to-back: second slice captured in the frame_done cycle
        r  = '{5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom)};
        rb = '{5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom)};
        c  = '{{$urandom, $urandom} | 64'h1, 64'h0, {$urandom, $urandom} | 64'h2, 64'h0};
        cb = '{64'h0, {$urandom, $urandom} | 64'h4, 64'h0, {$urandom, $urandom} | 64'h8};
        fg  = 9'($urandom);
        fgb = 9'($urandom);
        bus4.hub75_ready = 1'b1;
        drive4(r, c, fg, 1'b1);
        bus4.in_valid = 1'b1;
        @(posedge clk); #1;
        drive4(rb, cb, fgb, 1'b1);
        chk_beat("b2b_a0", r, c, fg, 0);
        @(posedge clk); #1;
        chk_beat("b2b_a1", r, c, fg, 2);
        @(posedge clk); #1;
        chk_end("b2b_a");
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        chk_beat("b2b_b0", rb, cb, fgb, 1);
        @(posedge clk); #1;
        chk_beat("b2b_b1", rb, cb, fgb, 3);
        @(posedge clk); #1;
        chk_end("b2b_b");
        @(posedge clk); #1;
        chk("b2b_post_done", 64'(bus4.frame_done), 64'd0);

        // Randomized slices with random stalls
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < N4; i++) begin
                r[i] = 5'($urandom);
                c[i] = ($urandom_range(3) == 0) ? 64'h0 : {$urandom, $urandom};
            end
            do_slice("rnd", r, c, 9'($urandom), 1'($urandom), 0, 30);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
